vram_scheduler: RTL and testbench

// - Shares the single-port screen VRAM between the video fetch engine (pixel/attr reads) and CPU read/write traffic.
// - One RAM access slot per ce_7mn strobe. Video always wins its slot.
// - CPU writes are posted through a small FIFO, with read-after-write forwarding, so the CPU is stalled only when the FIFO is full or a read has no free slot.
// - Sits between the video controller's vram_addr/vram_dout path, the CPU memory decode and the VRAM macro.

---
 rtl/vram_scheduler.sv | 163 ++++++++++++++++
 tb/tb_vram_scheduler.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/vram_scheduler.sv
// vram_scheduler: gives each ce_7mn slot of the single-port screen VRAM to one
// master. Video fetches take priority. CPU reads wait for a free slot. CPU
// writes are queued in a posted-write FIFO, and a CPU read of a queued address
// is answered from the FIFO without using a slot.
module vram_scheduler #(
    parameter int AW     = 15,
    parameter int DW     = 8,
    parameter int WDEPTH = 4
) (
    input  logic                       clk_sys,
    input  logic                       nRESET,
    input  logic                       ce_7mn,
    input  logic                       vid_req,
    input  logic [AW-1:0]              vid_addr,
    output logic                       vid_valid,
    output logic [DW-1:0]              vid_data,
    input  logic                       cpu_rd_req,
    input  logic                       cpu_wr_req,
    input  logic [AW-1:0]              cpu_addr,
    input  logic [DW-1:0]              cpu_din,
    output logic                       cpu_ack,
    output logic [DW-1:0]              cpu_dout,
    output logic                       cpu_wait,
    output logic [AW-1:0]              ram_addr,
    output logic [DW-1:0]              ram_din,
    output logic                       ram_we,
    input  logic [DW-1:0]              ram_dout,
    output logic [$clog2(WDEPTH):0]    wfifo_level,
    output logic                       wfifo_full,
    output logic [15:0]                stall_cnt
);
    localparam int PW = $clog2(WDEPTH);
    localparam int LW = PW + 1;

    typedef enum logic [1:0] {IDLE, RD_WAIT, RD_DATA, ACK} state_t;

    state_t          state, state_nxt;
    logic [AW-1:0]   fifo_addr [WDEPTH];
    logic [DW-1:0]   fifo_data [WDEPTH];
    logic [PW:0]     wptr, rptr;
    logic [PW-1:0]   head;
    logic            vid_slot, rd_slot, pop, push, fwd_hit, dout_load;
    logic [DW-1:0]   fwd_data, dout_nxt;
    logic [AW-1:0]   ram_addr_c, ram_addr_q;
    logic [DW-1:0]   ram_din_c, ram_din_q;
    logic            ram_we_c;
    logic            vid_vld_p1;
    logic [DW-1:0]   vid_data_p1;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign head        = rptr[PW-1:0];
    assign wfifo_level = wptr - rptr;
    assign wfifo_full  = (wfifo_level == LW'(WDEPTH));
    assign vid_slot    = ce_7mn && vid_req;
    assign rd_slot     = ce_7mn && !vid_req && (state == RD_WAIT);
    assign pop         = ce_7mn && !vid_req && (state != RD_WAIT) && (wfifo_level != '0);

    // Newest valid FIFO entry matching the CPU address; the head being popped is skipped
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        for (int k = 0; k < WDEPTH; k++) begin
            if ((LW'(k) < wfifo_level) && !(pop && (k == 0)) &&
                (fifo_addr[head + PW'(k)] == cpu_addr)) begin
                fwd_hit  = 1'b1;
                fwd_data = fifo_data[head + PW'(k)];
            end
        end
    end

    // CPU FSM next state, FIFO push and read-data load
    always_comb begin
        state_nxt = state;
        push      = 1'b0;
        dout_load = 1'b0;
        dout_nxt  = ram_dout;
        case (state)
            IDLE: begin
                if (cpu_wr_req) begin
                    if (!wfifo_full || pop) begin
                        push      = 1'b1;
                        state_nxt = ACK;
                    end
                end else if (cpu_rd_req) begin
                    if (fwd_hit) begin
                        dout_load = 1'b1;
                        dout_nxt  = fwd_data;
                        state_nxt = ACK;
                    end else begin
                        state_nxt = RD_WAIT;
                    end
                end
            end
            RD_WAIT: if (rd_slot) state_nxt = RD_DATA;
            RD_DATA: begin
                dout_load = 1'b1;
                state_nxt = ACK;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Slot owner drives the RAM port; an idle slot keeps the last address/data
    always_comb begin
        ram_addr_c = ram_addr_q;
        ram_din_c  = ram_din_q;
        ram_we_c   = 1'b0;
        if (vid_slot) begin
            ram_addr_c = vid_addr;
        end else if (rd_slot) begin
            ram_addr_c = cpu_addr;
        end else if (pop) begin
            ram_addr_c = fifo_addr[head];
            ram_din_c  = fifo_data[head];
            ram_we_c   = 1'b1;
        end
    end

    assign ram_addr  = nRESET ? ram_addr_c : '0;
    assign ram_din   = nRESET ? ram_din_c  : '0;
    assign ram_we    = nRESET && ram_we_c;
    assign cpu_ack   = (state == ACK);
    assign cpu_wait  = nRESET && (cpu_rd_req || cpu_wr_req) && !cpu_ack;
    assign vid_valid = vid_vld_p1;
    assign vid_data  = vid_vld_p1 ? ram_dout : vid_data_p1;

    // Control state: FSM, FIFO pointers, held RAM port, video pulse, stall counter
    always_ff @(posedge clk_sys or negedge nRESET) begin
        if (!nRESET) begin
            state       <= IDLE;
            wptr        <= '0;
            rptr        <= '0;
            ram_addr_q  <= '0;
            ram_din_q   <= '0;
            cpu_dout    <= '0;
            vid_vld_p1  <= 1'b0;
            vid_data_p1 <= '0;
            stall_cnt   <= '0;
        end else begin
            state      <= state_nxt;
            ram_addr_q <= ram_addr_c;
            ram_din_q  <= ram_din_c;
            if (push) wptr <= wptr + LW'(1);
            if (pop)  rptr <= rptr + LW'(1);
            if (dout_load) cpu_dout <= dout_nxt;
            // ---- video read data returns one cycle after its slot ----
            vid_vld_p1 <= vid_slot;
            if (vid_vld_p1) vid_data_p1 <= ram_dout;
            if (cpu_wait) stall_cnt <= sat_inc(stall_cnt);
        end
    end

    // FIFO storage; only entries inside the pointer window are ever used
    always_ff @(posedge clk_sys) begin
        if (push) begin
            fifo_addr[wptr[PW-1:0]] <= cpu_addr;
            fifo_data[wptr[PW-1:0]] <= cpu_din;
        end
    end
endmodule

// File: tb/tb_vram_scheduler.sv
// Directed bench for vram_scheduler with a behavioural synchronous VRAM.
module tb_vram_scheduler;
    logic        clk_sys = 1'b0;
    logic        nRESET, ce_7mn, vid_req, cpu_rd_req, cpu_wr_req;
    logic [14:0] vid_addr, cpu_addr, ram_addr;
    logic [7:0]  vid_data, cpu_din, cpu_dout, ram_din, ram_dout;
    logic        vid_valid, cpu_ack, cpu_wait, ram_we, wfifo_full;
    logic [2:0]  wfifo_level;
    logic [15:0] stall_cnt;
    logic [7:0]  mem [0:32767];
    int          n_vec = 0;
    int          n_err = 0;

    always #5 clk_sys = ~clk_sys;

    vram_scheduler #(.AW(15), .DW(8), .WDEPTH(4)) dut (
        .clk_sys(clk_sys), .nRESET(nRESET), .ce_7mn(ce_7mn),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_valid(vid_valid), .vid_data(vid_data),
        .cpu_rd_req(cpu_rd_req), .cpu_wr_req(cpu_wr_req), .cpu_addr(cpu_addr),
        .cpu_din(cpu_din), .cpu_ack(cpu_ack), .cpu_dout(cpu_dout), .cpu_wait(cpu_wait),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_dout(ram_dout),
        .wfifo_level(wfifo_level), .wfifo_full(wfifo_full), .stall_cnt(stall_cnt)
    );

    // Synchronous single-port VRAM, one cycle read latency
    always @(posedge clk_sys) begin
        if (ram_we) mem[ram_addr] <= ram_din;
        ram_dout <= mem[ram_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    // Posted write from IDLE; ack is due in the following cycle
    task automatic do_write(input logic [14:0] a, input logic [7:0] d);
        cpu_addr   = a;
        cpu_din    = d;
        cpu_wr_req = 1'b1;
        tick();
        chk("wr_ack", 32'(cpu_ack), 32'h1);
        cpu_wr_req = 1'b0;
        tick();
    endtask

    initial begin
        for (int i = 0; i < 32768; i++) mem[i] = 8'(i) ^ 8'(i >> 8);
        mem[15'h1800] = 8'h3C;
        mem[15'h0100] = 8'h77;
        mem[15'h0010] = 8'h99;
        nRESET = 1'b0; ce_7mn = 1'b0; vid_req = 1'b0; vid_addr = '0;
        cpu_rd_req = 1'b1; cpu_wr_req = 1'b0; cpu_addr = '0; cpu_din = '0;
        repeat (3) tick();
        chk("rst_ack",   32'(cpu_ack), 32'h0);
        chk("rst_vvld",  32'(vid_valid), 32'h0);
        chk("rst_we",    32'(ram_we), 32'h0);
        chk("rst_addr",  32'(ram_addr), 32'h0);
        chk("rst_level", 32'(wfifo_level), 32'h0);
        chk("rst_full",  32'(wfifo_full), 32'h0);
        chk("rst_stall", 32'(stall_cnt), 32'h0);
        chk("rst_wait",  32'(cpu_wait), 32'h0);
        cpu_rd_req = 1'b0;
        nRESET = 1'b1;
        tick();

        // Video fetch: address in the slot cycle, data the next cycle
        ce_7mn = 1'b1; vid_req = 1'b1; vid_addr = 15'h1800;
        #1;
        chk("vid_addr", 32'(ram_addr), 32'h1800);
        chk("vid_we",   32'(ram_we), 32'h0);
        tick();
        ce_7mn = 1'b0; vid_req = 1'b0;
        #1;
        chk("vid_valid", 32'(vid_valid), 32'h1);
        chk("vid_data",  32'(vid_data), 32'h3C);
        tick();
        chk("vid_pulse", 32'(vid_valid), 32'h0);
        chk("vid_hold",  32'(vid_data), 32'h3C);

        // CPU read held off by three video slots
        cpu_addr = 15'h0010; cpu_rd_req = 1'b1;
        #1;
        chk("pri_wait", 32'(cpu_wait), 32'h1);
        tick();
        ce_7mn = 1'b1; vid_req = 1'b1; vid_addr = 15'h1800;
        repeat (3) begin
            #1;
            chk("pri_vslot", 32'(ram_addr), 32'h1800);
            tick();
        end
        vid_req = 1'b0;
        #1;
        chk("pri_grant", 32'(ram_addr), 32'h0010);
        chk("pri_noack", 32'(cpu_ack), 32'h0);
        tick();
        ce_7mn = 1'b0;
        #1;
        chk("pri_noack2", 32'(cpu_ack), 32'h0);
        tick();
        chk("pri_ack",   32'(cpu_ack), 32'h1);
        chk("pri_dout",  32'(cpu_dout), 32'h99);
        chk("pri_stall", 32'(stall_cnt), 32'd6);
        cpu_rd_req = 1'b0;
        tick();
        chk("pri_ackend", 32'(cpu_ack), 32'h0);

        // FIFO fills while video owns every slot
        ce_7mn = 1'b1; vid_req = 1'b1;
        for (int i = 0; i < 4; i++) do_write(15'h4000 + 15'(i), 8'(8'h11 * (i + 1)));
        chk("full_level", 32'(wfifo_level), 32'd4);
        chk("full_flag",  32'(wfifo_full), 32'h1);
        cpu_addr = 15'h4004; cpu_din = 8'h55; cpu_wr_req = 1'b1;
        repeat (3) begin
            tick();
            chk("full_hold", 32'(cpu_ack), 32'h0);
        end
        chk("full_flag2", 32'(wfifo_full), 32'h1);
        chk("full_wait",  32'(cpu_wait), 32'h1);
        vid_req = 1'b0;
        #1;
        chk("drain_we0",  32'(ram_we), 32'h1);
        chk("drain_a0",   32'(ram_addr), 32'h4000);
        chk("drain_d0",   32'(ram_din), 32'h11);
        tick();
        chk("drain_ack",  32'(cpu_ack), 32'h1);
        chk("drain_lvl",  32'(wfifo_level), 32'd4);
        cpu_wr_req = 1'b0;
        #1;
        chk("drain_a1",   32'(ram_addr), 32'h4001);
        chk("drain_d1",   32'(ram_din), 32'h22);
        for (int i = 2; i < 5; i++) begin
            tick();
            chk("drain_an", 32'(ram_addr), 32'h4000 + 32'(i));
            chk("drain_dn", 32'(ram_din), 32'(8'h11 * (i + 1)));
        end
        tick();
        chk("drain_empty", 32'(wfifo_level), 32'd0);
        chk("drain_idle",  32'(ram_we), 32'h0);
        chk("drain_mem0",  32'(mem[15'h4000]), 32'h11);
        chk("drain_mem4",  32'(mem[15'h4004]), 32'h55);

        // Read-after-write forwarding with no slots available
        ce_7mn = 1'b0;
        do_write(15'h0200, 8'hA5);
        do_write(15'h0200, 8'h5A);
        chk("fwd_level", 32'(wfifo_level), 32'd2);
        cpu_addr = 15'h0200; cpu_rd_req = 1'b1;
        #1;
        chk("fwd_addr0", 32'(ram_addr), 32'h4004);
        tick();
        chk("fwd_ack",   32'(cpu_ack), 32'h1);
        chk("fwd_dout",  32'(cpu_dout), 32'h5A);
        chk("fwd_addr1", 32'(ram_addr), 32'h4004);
        chk("fwd_we",    32'(ram_we), 32'h0);
        cpu_rd_req = 1'b0;
        tick();
        ce_7mn = 1'b1;
        repeat (2) tick();
        chk("fwd_empty", 32'(wfifo_level), 32'd0);
        ce_7mn = 1'b0;
        tick();
        chk("fwd_mem", 32'(mem[15'h0200]), 32'h5A);

        // Reset while the read data is returning
        cpu_addr = 15'h0100; cpu_rd_req = 1'b1;
        tick();
        ce_7mn = 1'b1;
        #1;
        chk("mrst_grant", 32'(ram_addr), 32'h0100);
        tick();
        ce_7mn = 1'b0;
        nRESET = 1'b0;
        #1;
        chk("mrst_ack",   32'(cpu_ack), 32'h0);
        chk("mrst_lvl",   32'(wfifo_level), 32'd0);
        chk("mrst_stall", 32'(stall_cnt), 32'h0);
        chk("mrst_addr",  32'(ram_addr), 32'h0);
        chk("mrst_dout",  32'(cpu_dout), 32'h0);
        chk("mrst_wait",  32'(cpu_wait), 32'h0);
        repeat (2) begin
            tick();
            chk("mrst_noack", 32'(cpu_ack), 32'h0);
        end
        cpu_rd_req = 1'b0;
        nRESET = 1'b1;
        tick();
        cpu_rd_req = 1'b1; ce_7mn = 1'b1;
        tick();
        #1;
        chk("post_grant", 32'(ram_addr), 32'h0100);
        tick();
        ce_7mn = 1'b0;
        tick();
        chk("post_ack",  32'(cpu_ack), 32'h1);
        chk("post_dout", 32'(cpu_dout), 32'h77);
        cpu_rd_req = 1'b0;
        tick();

        // Stall counter saturation behind a full FIFO
        for (int i = 0; i < 4; i++) do_write(15'h7000 + 15'(i), 8'(i));
        cpu_addr = 15'h7004; cpu_din = 8'hEE; cpu_wr_req = 1'b1;
        repeat (70000) tick();
        chk("sat_val",  32'(stall_cnt), 32'hFFFF);
        chk("sat_wait", 32'(cpu_wait), 32'h1);
        repeat (10) tick();
        chk("sat_hold", 32'(stall_cnt), 32'hFFFF);
        ce_7mn = 1'b1;
        tick();
        chk("sat_ack", 32'(cpu_ack), 32'h1);
        cpu_wr_req = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
